fp12_mult_arb: RTL and testbench

FP12_MULT_ARB -- requirements
Module: fp12_mult_arb

---
 rtl/fp12_mult_arb.sv | 170 +++++++++++++++++
 tb/tb_fp12_mult_arb.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp12_mult_arb.sv
// fp12_mult_arb: one shared FP12 multiplier behind a round-robin arbiter.
//
// FP12 layout: [11] sign, [10:6] exponent (bias 15), [5:0] fraction.
//   exponent 0        -> zero (subnormal inputs are flushed to zero)
//   exponent 31, f=0  -> infinity
//   exponent 31, f!=0 -> NaN
// Products are truncated toward zero. Results that overflow become a signed infinity,
// and results that underflow become a signed zero. NaN inputs and inf*0 both return
// the canonical NaN 12'h7E0.

module fp12_mult (
    input  logic [11:0] a,
    input  logic [11:0] b,
    output logic [11:0] p
);
    logic        sign;
    logic [4:0]  ea;
    logic [4:0]  eb;
    logic [5:0]  ma;
    logic [5:0]  mb;
    logic        a_zero;
    logic        b_zero;
    logic        a_inf;
    logic        b_inf;
    logic        a_nan;
    logic        b_nan;
    logic [13:0] prod;
    logic        norm;
    logic [5:0]  frac;
    logic [6:0]  e_total;

    // Decode both operands, multiply the significands and classify the result.
    // e_total is the biased exponent sum before the bias is removed. Keeping it
    // unsigned means underflow is simply e_total <= 15, and overflow is e_total >= 46.
    always_comb begin
        ea      = a[10:6];
        eb      = b[10:6];
        ma      = a[5:0];
        mb      = b[5:0];
        sign    = a[11] ^ b[11];
        a_zero  = (ea == 5'd0);
        b_zero  = (eb == 5'd0);
        a_inf   = (ea == 5'd31) && (ma == 6'd0);
        b_inf   = (eb == 5'd31) && (mb == 6'd0);
        a_nan   = (ea == 5'd31) && (ma != 6'd0);
        b_nan   = (eb == 5'd31) && (mb != 6'd0);
        prod    = 14'({1'b1, ma}) * 14'({1'b1, mb});
        norm    = prod[13];
        frac    = norm ? prod[12:7] : prod[11:6];
        e_total = 7'(ea) + 7'(eb) + 7'(norm);
        p       = {sign, 11'd0};
        if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
            p = 12'h7E0;
        end else if (a_inf || b_inf) begin
            p = {sign, 5'h1F, 6'd0};
        end else if (a_zero || b_zero) begin
            p = {sign, 11'd0};
        end else if (e_total >= 7'd46) begin
            p = {sign, 5'h1F, 6'd0};
        end else if (e_total <= 7'd15) begin
            p = {sign, 11'd0};
        end else begin
            p = {sign, 5'(e_total - 7'd15), frac};
        end
    end
endmodule

module fp12_mult_arb #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [12*NREQ-1:0]   req_in1,
    input  logic [12*NREQ-1:0]   req_in2,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [11:0]          res_out,
    output logic [IDW-1:0]       res_id,
    output logic                 busy
);
    // Stage 1 holds the operands that feed the multiplier.
    logic            s1_v;
    logic [11:0]     s1_a;
    logic [11:0]     s1_b;
    logic [IDW-1:0]  s1_id;

    // Stage 2 holds the product that drives the result port.
    logic            s2_v;
    logic [11:0]     s2_p;
    logic [IDW-1:0]  s2_id;

    logic [IDW-1:0]  ptr;
    logic [IDW-1:0]  grant_id;
    logic [IDW-1:0]  next_ptr;
    logic            found;
    logic            s1_adv;
    logic            s2_adv;
    logic            hs;
    logic [11:0]     mult_out;

    assign s2_adv = !s2_v || res_ready;
    assign s1_adv = !s1_v || s2_adv;

    fp12_mult u_mult (
        .a (s1_a),
        .b (s1_b),
        .p (mult_out)
    );

    // Round-robin search from ptr. The ready is gated by s1_adv and by reset, so at
    // most one requester sees ready, and only when stage 1 can accept.
    always_comb begin
        int j;
        found     = 1'b0;
        grant_id  = '0;
        j         = 0;
        for (int k = 0; k < NREQ; k++) begin
            j = (int'(ptr) + k) % NREQ;
            if (!found && req_valid[j]) begin
                found    = 1'b1;
                grant_id = IDW'(j);
            end
        end
        req_ready = '0;
        if (found && s1_adv && !rst) begin
            req_ready[grant_id] = 1'b1;
        end
    end

    assign hs       = |req_ready;
    assign next_ptr = (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + 1'b1;

    // Pipeline and pointer state. S2 samples the multiplier whenever it may advance.
    // S1 reloads on a handshake, and drains to empty when it advances without one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_v  <= 1'b0;
            s1_a  <= '0;
            s1_b  <= '0;
            s1_id <= '0;
            s2_v  <= 1'b0;
            s2_p  <= '0;
            s2_id <= '0;
            ptr   <= '0;
        end else begin
            if (s2_adv) begin
                s2_v  <= s1_v;
                s2_p  <= mult_out;
                s2_id <= s1_id;
            end
            if (s1_adv) begin
                s1_v <= hs;
                if (hs) begin
                    s1_a  <= req_in1[12*grant_id +: 12];
                    s1_b  <= req_in2[12*grant_id +: 12];
                    s1_id <= grant_id;
                    ptr   <= next_ptr;
                end
            end
        end
    end

    assign res_valid = s2_v;
    assign res_out   = s2_p;
    assign res_id    = s2_id;
    assign busy      = s1_v || s2_v;
endmodule

// File: tb/tb_fp12_mult_arb.sv
// tb_fp12_mult_arb: a directed and random bench with a scoreboard for fp12_mult_arb.
// A negedge tracker pushes the expected {id, product} for each accepted request.
// The same process pops the scoreboard and compares each result the DUT transfers.

module tb_fp12_mult_arb;
    logic         clk;
    logic         rst;
    logic [3:0]   req_valid;
    logic [3:0]   req_ready;
    logic [47:0]  req_in1;
    logic [47:0]  req_in2;
    logic         res_valid;
    logic         res_ready;
    logic [11:0]  res_out;
    logic [1:0]   res_id;
    logic         busy;

    int           n_checks;
    int           n_fail;
    logic [11:0]  slot [4];
    logic [13:0]  sb [$];
    int           grant_log [$];

    logic         m_s1v;
    logic         m_s2v;
    int           m_ptr;

    fp12_mult_arb #(.NREQ(4), .IDW(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_in1   (req_in1),
        .req_in2   (req_in2),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_out   (res_out),
        .res_id    (res_id),
        .busy      (busy)
    );

    // 100 MHz clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic real pow2(input int k);
        real r;
        r = 1.0;
        if (k >= 0) for (int i = 0; i < k; i++) r = r * 2.0;
        else        for (int i = 0; i < -k; i++) r = r / 2.0;
        return r;
    endfunction

    // Reference product built from real arithmetic, then re-encoded by truncation.
    function automatic logic [11:0] fp_model(input logic [11:0] a, input logic [11:0] b);
        int  ea, eb, ma, mb, e;
        logic s;
        real v;
        ea = int'(a[10:6]); eb = int'(b[10:6]);
        ma = int'(a[5:0]);  mb = int'(b[5:0]);
        s  = a[11] ^ b[11];
        if ((ea == 31 && ma != 0) || (eb == 31 && mb != 0) ||
            (ea == 31 && eb == 0) || (eb == 31 && ea == 0)) return 12'h7E0;
        if (ea == 31 || eb == 31) return {s, 5'h1F, 6'd0};
        if (ea == 0 || eb == 0) return {s, 11'd0};
        v = (real'(64 + ma) / 64.0) * pow2(ea - 15) * (real'(64 + mb) / 64.0) * pow2(eb - 15);
        if (v >= pow2(16)) return {s, 5'h1F, 6'd0};
        if (v < pow2(-14)) return {s, 11'd0};
        e = 1;
        while (!(v >= pow2(e - 15) && v < pow2(e - 14))) e++;
        return {s, 5'(e), 6'($rtoi((v / pow2(e - 15) - 1.0) * 64.0))};
    endfunction

    // Tracker and monitor: check the outputs against the bench model, retire results,
    // then record any expected handshake and step the model to the next edge.
    always @(negedge clk) begin
        logic       s1_adv;
        logic       s2_adv;
        int         g;
        int         j;
        logic [3:0] exp_ready;
        logic [13:0] e;
        if (rst) begin
            m_s1v = 1'b0;
            m_s2v = 1'b0;
            m_ptr = 0;
            check_output("rst_res_valid", 32'(res_valid), 32'd0);
            check_output("rst_busy", 32'(busy), 32'd0);
            check_output("rst_req_ready", 32'(req_ready), 32'd0);
        end else begin
            check_output("res_valid", 32'(res_valid), 32'(m_s2v));
            check_output("busy", 32'(busy), 32'(m_s1v | m_s2v));
            if (res_valid && res_ready) begin
                if (sb.size() == 0) begin
                    check_output("unexpected_result", 32'(res_out), 32'hFFFF_FFFF);
                end else begin
                    e = sb.pop_front();
                    check_output("res_id", 32'(res_id), 32'(e[13:12]));
                    check_output("res_out", 32'(res_out), 32'(e[11:0]));
                end
            end
            s2_adv = !m_s2v || res_ready;
            s1_adv = !m_s1v || s2_adv;
            g = -1;
            for (int k = 0; k < 4; k++) begin
                j = (m_ptr + k) % 4;
                if (g < 0 && req_valid[j]) g = j;
            end
            exp_ready = (s1_adv && g >= 0) ? 4'(1 << g) : 4'd0;
            check_output("req_ready", 32'(req_ready), 32'(exp_ready));
            if (s2_adv) m_s2v = m_s1v;
            if (s1_adv) m_s1v = (exp_ready != 4'd0);
            if (exp_ready != 4'd0) begin
                sb.push_back({2'(g), slot[g]});
                grant_log.push_back(g);
                m_ptr = (g + 1) % 4;
            end
        end
    end

    task automatic set_req(input int i, input logic [11:0] a, input logic [11:0] b, input logic [11:0] e);
        req_in1[12*i +: 12] = a;
        req_in2[12*i +: 12] = b;
        slot[i]             = e;
        req_valid[i]        = 1'b1;
    endtask

    task automatic reset_dut();
        rst       = 1'b1;
        req_valid = '0;
        res_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        sb.delete();
        rst = 1'b0;
        grant_log.delete();
    endtask

    task automatic wait_grant(input int i);
        logic got;
        got = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (req_ready[i]) begin
                got = 1'b1;
                break;
            end
        end
        check_output("grant_timeout", 32'(got), 32'd1);
        @(posedge clk);
        #1;
        req_valid[i] = 1'b0;
    endtask

    task automatic drain();
        res_ready = 1'b1;
        for (int k = 0; k < 50 && (sb.size() != 0 || busy); k++) @(posedge clk);
        #1;
        check_output("drain_timeout", 32'(sb.size()), 32'd0);
    endtask

    task automatic apply_stimulus();
        int rr_exp [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
        logic [11:0] a, b;

        // A single request is accepted on the first edge after reset release.
        reset_dut();
        check_output("reset_res_out", 32'(res_out), 32'h000);
        check_output("reset_res_id", 32'(res_id), 32'd0);
        set_req(0, 12'h038, 12'h038, 12'h000);
        wait_grant(0);
        drain();

        // Round robin with all four requesters valid for 8 cycles.
        reset_dut();
        set_req(0, 12'h3C0, 12'h3C0, 12'h3C0);
        set_req(1, 12'h400, 12'h3E0, 12'h420);
        set_req(2, 12'h7BF, 12'h7BF, 12'h7C0);
        set_req(3, 12'h040, 12'h040, 12'h000);
        repeat (8) @(posedge clk);
        #1;
        req_valid = '0;
        drain();
        check_output("rr_count", 32'(grant_log.size()), 32'd8);
        for (int k = 0; k < 8 && k < grant_log.size(); k++)
            check_output("rr_order", 32'(grant_log[k]), 32'(rr_exp[k]));

        // Backpressure: req 2 waits in S2, req 3 waits in S1, and req 0 is refused.
        reset_dut();
        res_ready = 1'b0;
        set_req(2, 12'h30A, 12'hEC0, 12'hE0A);
        set_req(3, 12'h3FF, 12'hEFF, 12'hF3E);
        @(posedge clk); #1; req_valid[2] = 1'b0;
        @(posedge clk); #1; req_valid[3] = 1'b0;
        set_req(0, 12'h3C0, 12'h3C0, 12'h3C0);
        repeat (5) begin
            @(negedge clk);
            check_output("stall_valid", 32'(res_valid), 32'd1);
            check_output("stall_id", 32'(res_id), 32'd2);
            check_output("stall_out", 32'(res_out), 32'hE0A);
            check_output("stall_ready", 32'(req_ready), 32'd0);
        end
        @(posedge clk); #1; res_ready = 1'b1;
        @(negedge clk);
        check_output("bp_first_id", 32'(res_id), 32'd2);
        @(posedge clk); #1; req_valid[0] = 1'b0;
        @(negedge clk);
        check_output("bp_second_valid", 32'(res_valid), 32'd1);
        check_output("bp_second_id", 32'(res_id), 32'd3);
        check_output("bp_second_out", 32'(res_out), 32'hF3E);
        drain();

        // Pointer skip: with ptr=1 and requesters 0 and 3 valid, 3 wins and then 0.
        reset_dut();
        set_req(0, 12'hBC0, 12'h400, 12'hC00);
        wait_grant(0);
        drain();
        grant_log.delete();
        set_req(0, 12'h400, 12'h3E0, 12'h420);
        set_req(3, 12'h7C0, 12'h000, 12'h7E0);
        @(negedge clk);
        check_output("skip_first", 32'(req_ready), 32'b1000);
        @(posedge clk); #1; req_valid[3] = 1'b0;
        @(negedge clk);
        check_output("skip_second", 32'(req_ready), 32'b0001);
        @(posedge clk); #1; req_valid[0] = 1'b0;
        drain();

        // Reset while both stages are full discards the work in flight.
        reset_dut();
        res_ready = 1'b0;
        set_req(1, 12'h3C0, 12'h400, 12'h400);
        set_req(2, 12'h400, 12'h400, 12'h440);
        repeat (2) @(posedge clk);
        #1;
        req_valid = 4'b0001;
        res_ready = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        check_output("midrst_res_valid", 32'(res_valid), 32'd0);
        check_output("midrst_busy", 32'(busy), 32'd0);
        check_output("midrst_req_ready", 32'(req_ready), 32'd0);
        sb.delete();
        req_valid = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check_output("midrst_idle", 32'(busy), 32'd0);

        // Random traffic. Operands change every cycle, including on waiting requesters.
        reset_dut();
        for (int c = 0; c < 10000; c++) begin
            @(posedge clk);
            #1;
            res_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < 4; i++) begin
                a = 12'($urandom);
                b = 12'($urandom);
                req_in1[12*i +: 12] = a;
                req_in2[12*i +: 12] = b;
                slot[i]             = fp_model(a, b);
                req_valid[i]        = ($urandom_range(0, 1) == 1);
            end
        end
        req_valid = '0;
        drain();
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rst       = 1'b1;
        req_valid = '0;
        req_in1   = '0;
        req_in2   = '0;
        res_ready = 1'b1;
        for (int i = 0; i < 4; i++) slot[i] = '0;
        apply_stimulus();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Watchdog in case the run stalls.
    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
